// File: rtl/riscv_fetch.sv
// Instruction fetch stage: owns the PC, issues one request at a time to the I-cache,
// buffers responses in a 2-entry queue for decode and handles execute redirects.
// Optional build macro: RISCV_FETCH_FAULT_STOP_EN (halt fetch after a faulting entry until redirect).
module riscv_fetch #(
    parameter logic [31:0] BOOT_VECTOR = 32'h80000000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_request,
    input  logic [31:0] branch_pc,
    output logic        squash_out,
    output logic        icache_rd,
    output logic [31:0] icache_pc,
    input  logic        icache_accept,
    input  logic        icache_valid,
    input  logic [31:0] icache_inst,
    input  logic        icache_error,
    input  logic        icache_page_fault,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        fetch_fault_fetch,
    output logic        fetch_fault_page,
    input  logic        fetch_accept
);

    if (QUEUE_DEPTH != 2) begin : g_bad_depth
        $error("riscv_fetch: QUEUE_DEPTH must be 2");
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
        logic        pf;
    } entry_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        discard_q, discard_d;
    logic [1:0]  count_q, count_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic        stop_fetch;

    logic        pop;
    logic        push;
    logic        fire;
    logic        credit_ok;
    entry_t      push_entry;

`ifdef RISCV_FETCH_FAULT_STOP_EN
    logic stopped_q, stopped_d;
    assign stop_fetch = stopped_q;
`else
    assign stop_fetch = 1'b0;
`endif

    assign pop  = (count_q != 2'd0) && fetch_accept;
    assign push = icache_valid && !discard_q && !branch_request;
    assign fire = icache_rd && icache_accept;

    // A returning response frees the outstanding slot but still lands in the queue,
    // so it keeps counting against queue credit this cycle.
    assign credit_ok = ({1'b0, count_q} + {2'b00, outstanding_q} - {2'b00, pop}) < 3'd2;
    assign icache_rd = rst_n && credit_ok && !(outstanding_q && !icache_valid) && !stop_fetch;
    assign icache_pc = pc_q;

    assign squash_out = branch_request;

    always_comb begin
        push_entry.instr = (icache_error || icache_page_fault) ? 32'h0 : icache_inst;
        push_entry.pc    = out_pc_q;
        push_entry.err   = icache_error;
        push_entry.pf    = icache_page_fault;
    end

    always_comb begin
        pc_d          = pc_q;
        out_pc_d      = out_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;

        if (fire) begin
            outstanding_d = 1'b1;
            out_pc_d      = pc_q;
            pc_d          = pc_q + 32'd4;
        end else if (icache_valid) begin
            outstanding_d = 1'b0;
        end

        if (icache_valid && discard_q) begin
            discard_d = 1'b0;
        end

        if (push && pop) begin
            if (count_q == 2'd2) begin
                head_d = tail_q;
                tail_d = push_entry;
            end else begin
                head_d = push_entry;
            end
        end else if (push) begin
            if (count_q == 2'd0) head_d = push_entry;
            else                 tail_d = push_entry;
            count_d = count_q + 2'd1;
        end else if (pop) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end

        // Redirect overrides everything above; an in-flight or just-accepted fetch is stale.
        if (branch_request) begin
            pc_d      = {branch_pc[31:2], 2'b00};
            count_d   = 2'd0;
            discard_d = (outstanding_q && !icache_valid) || fire;
        end
    end

`ifdef RISCV_FETCH_FAULT_STOP_EN
    always_comb begin
        stopped_d = stopped_q;
        if (branch_request)                                      stopped_d = 1'b0;
        else if (push && (icache_error || icache_page_fault))    stopped_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stopped_q <= 1'b0;
        else        stopped_q <= stopped_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= BOOT_VECTOR;
            out_pc_q      <= 32'h0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            out_pc_q      <= out_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
        end
    end

    // NOTE: queue payload is not reset; outputs are gated by fetch_valid, so stale data never escapes.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign fetch_valid       = (count_q != 2'd0);
    assign fetch_instr       = fetch_valid ? head_q.instr : 32'h0;
    assign fetch_pc          = fetch_valid ? head_q.pc    : 32'h0;
    assign fetch_fault_fetch = fetch_valid && head_q.err;
    assign fetch_fault_page  = fetch_valid && head_q.pf;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_riscv_fetch.sv
// Self-checking bench for riscv_fetch: cycle table, directed corner sequences and a
// randomized run scored against the program-order instruction stream.
module tb_riscv_fetch;

    localparam logic [31:0] BOOT = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_request;
    logic [31:0] branch_pc;
    logic        squash_out;
    logic        icache_rd;
    logic [31:0] icache_pc;
    logic        icache_accept;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        icache_error;
    logic        icache_page_fault;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_fault_fetch;
    logic        fetch_fault_page;
    logic        fetch_accept;

    riscv_fetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .branch_request    (branch_request),
        .branch_pc         (branch_pc),
        .squash_out        (squash_out),
        .icache_rd         (icache_rd),
        .icache_pc         (icache_pc),
        .icache_accept     (icache_accept),
        .icache_valid      (icache_valid),
        .icache_inst       (icache_inst),
        .icache_error      (icache_error),
        .icache_page_fault (icache_page_fault),
        .fetch_valid       (fetch_valid),
        .fetch_instr       (fetch_instr),
        .fetch_pc          (fetch_pc),
        .fetch_fault_fetch (fetch_fault_fetch),
        .fetch_fault_page  (fetch_fault_page),
        .fetch_accept      (fetch_accept)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Cache model and program-order scoreboard state.
    bit          cm_pend;
    logic [31:0] cm_pc;
    int          cm_delay;
    logic [31:0] exp_pc;
    bit          prev_ok;
    logic [31:0] prev_pc;
    int          delivered;
    bit          rand_faults;
    logic [31:0] pf_pc;
    bit          fault_head_seen;
    int          rd_after_fault;
    bit          saw_fault_10;
    bit          obs_rd;
    logic [31:0] obs_pc;

    typedef struct {
        bit          br;
        logic [31:0] bpc;
        bit          acc;
        bit          vld;
        logic [31:0] rpc;
        bit          fa;
        bit          e_rd;
        logic [31:0] e_ipc;
        bit          e_fv;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h13579BDF;
    endfunction

    function automatic bit pf_of(input logic [31:0] pc);
        return (pc == pf_pc) || (rand_faults && pc[6:2] == 5'h17);
    endfunction

    function automatic bit err_of(input logic [31:0] pc);
        return rand_faults && pc[6:2] == 5'h0B;
    endfunction

    function automatic vec_t mk(input bit br, input logic [31:0] bpc, input bit acc, input bit vld,
                                input logic [31:0] rpc, input bit fa, input bit e_rd,
                                input logic [31:0] e_ipc, input bit e_fv, input logic [31:0] e_fpc);
        vec_t v;
        v.br = br; v.bpc = bpc; v.acc = acc; v.vld = vld; v.rpc = rpc; v.fa = fa;
        v.e_rd = e_rd; v.e_ipc = e_ipc; v.e_fv = e_fv; v.e_fpc = e_fpc;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        branch_request = 1'b0; branch_pc = 32'h0; icache_accept = 1'b0;
        icache_valid = 1'b0; icache_inst = 32'h0; icache_error = 1'b0;
        icache_page_fault = 1'b0; fetch_accept = 1'b0;
        @(negedge clk);
        #1;
        check("rst_icache_rd", icache_rd, 0);
        check("rst_icache_pc", icache_pc, BOOT);
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_fetch_instr", fetch_instr, 0);
        check("rst_fetch_pc", fetch_pc, 0);
        check("rst_faults", {fetch_fault_fetch, fetch_fault_page}, 0);
        rst_n = 1'b1;
        cm_pend = 0; cm_delay = 0; exp_pc = BOOT; prev_ok = 0;
    endtask

    task automatic run_cycle(input bit br, input logic [31:0] bpc, input bit acc, input bit fa,
                             input int lat_max);
        bit resp;
        bit fire;
        bit efp;
        bit efe;
        @(negedge clk);
        resp = cm_pend && (cm_delay == 0);
        icache_valid      = resp;
        icache_inst       = resp ? inst_of(cm_pc) : $urandom;
        icache_error      = resp && err_of(cm_pc);
        icache_page_fault = resp && pf_of(cm_pc);
        branch_request = br; branch_pc = bpc; icache_accept = acc; fetch_accept = fa;
        #1;
        obs_rd = icache_rd;
        obs_pc = icache_pc;
        fire = icache_rd && acc;
        check("squash", squash_out, br);
        if (prev_ok) check("pc_hold", icache_pc, prev_pc);
        if (fire) check("single_outstanding", cm_pend && !resp, 0);
        if (icache_rd) check("pc_align", icache_pc[1:0], 0);
        if (fetch_valid && (fetch_fault_page || fetch_fault_fetch)) fault_head_seen = 1;
        if (fault_head_seen && icache_rd && !br) rd_after_fault++;
        if (fetch_valid && fa && !br) begin
            efp = pf_of(exp_pc);
            efe = err_of(exp_pc);
            check("deliver_pc", fetch_pc, exp_pc);
            check("deliver_instr", fetch_instr, (efp || efe) ? 32'h0 : inst_of(exp_pc));
            check("deliver_faults", {fetch_fault_fetch, fetch_fault_page}, {efe, efp});
            if (exp_pc == 32'h80000010 && fetch_fault_page && fetch_instr == 32'h0) saw_fault_10 = 1;
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (br) begin
            exp_pc = bpc & ~32'h3;
            fault_head_seen = 0;
        end
        if (resp) cm_pend = 0;
        else if (cm_pend && cm_delay > 0) cm_delay--;
        if (fire) begin
            cm_pend  = 1;
            cm_pc    = icache_pc;
            cm_delay = $urandom_range(0, lat_max);
        end
        prev_pc = icache_pc;
        prev_ok = !fire && !br;
    endtask

    initial begin
        rand_faults = 0;
        pf_pc = 32'h1;
        delivered = 0;
        fault_head_seen = 0;
        rd_after_fault = 0;
        saw_fault_10 = 0;

        // Cycle table: streaming, backpressure, redirect with stale outstanding, redirect on response+pop.
        vecs.push_back(mk(0, 0, 1, 0, 0,            1, 1, 32'h80000000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h80000000, 1, 1, 32'h80000004, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h80000004, 1, 1, 32'h80000008, 1, 32'h80000000));
        vecs.push_back(mk(0, 0, 1, 1, 32'h80000008, 0, 0, 32'h8000000C, 1, 32'h80000004));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h8000000C, 1, 32'h80000004));
        vecs.push_back(mk(0, 0, 1, 0, 0,            1, 1, 32'h8000000C, 1, 32'h80000004));
        vecs.push_back(mk(0, 0, 0, 1, 32'h8000000C, 1, 1, 32'h80000010, 1, 32'h80000008));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'h80000010, 1, 32'h8000000C));
        vecs.push_back(mk(1, 32'h80001003, 1, 0, 0, 1, 1, 32'h80000010, 1, 32'h8000000C));
        vecs.push_back(mk(0, 0, 1, 1, 32'h80000010, 1, 1, 32'h80001000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h80001000, 0, 1, 32'h80001004, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 1, 32'h80001004, 1, 32'h80001000));
        vecs.push_back(mk(1, 32'h80002000, 0, 1, 32'h80001004, 1, 1, 32'h80001008, 1, 32'h80001000));
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 1, 32'h80002000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,            1, 1, 32'h80002000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h80002000, 1, 1, 32'h80002004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 1, 32'h80002004, 1, 32'h80002000));

        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            branch_request = vecs[i].br; branch_pc = vecs[i].bpc;
            icache_accept = vecs[i].acc; icache_valid = vecs[i].vld;
            icache_inst = vecs[i].vld ? inst_of(vecs[i].rpc) : $urandom;
            icache_error = 1'b0; icache_page_fault = 1'b0;
            fetch_accept = vecs[i].fa;
            #1;
            check($sformatf("vec%0d_rd", i), icache_rd, vecs[i].e_rd);
            check($sformatf("vec%0d_ipc", i), icache_pc, vecs[i].e_ipc);
            check($sformatf("vec%0d_fv", i), fetch_valid, vecs[i].e_fv);
            check($sformatf("vec%0d_squash", i), squash_out, vecs[i].br);
            if (vecs[i].e_fv) begin
                check($sformatf("vec%0d_fpc", i), fetch_pc, vecs[i].e_fpc);
                check($sformatf("vec%0d_finstr", i), fetch_instr, inst_of(vecs[i].e_fpc));
                check($sformatf("vec%0d_fault", i), {fetch_fault_fetch, fetch_fault_page}, 0);
            end
        end

        // Page fault on 0x80000010 with a 1-cycle cache and decode always accepting.
        do_reset();
        pf_pc = 32'h80000010;
        fault_head_seen = 0; rd_after_fault = 0; saw_fault_10 = 0;
        for (int i = 0; i < 14; i++) run_cycle(0, 32'h0, 1, 1, 0);
        check("fault10_delivered", saw_fault_10, 1);
`ifdef RISCV_FETCH_FAULT_STOP_EN
        check("stop_after_fault", rd_after_fault, 0);
`else
        check("continue_after_fault", rd_after_fault > 0, 1);
`endif
        pf_pc = 32'h1;
        run_cycle(1, 32'h80000100, 1, 1, 0);
        run_cycle(0, 32'h0, 0, 1, 0);
        check("resume_rd", obs_rd, 1);
        check("resume_pc", obs_pc, 32'h80000100);
        for (int i = 0; i < 4; i++) run_cycle(0, 32'h0, 1, 1, 0);

        // Sequential wrap at the top of the address space.
        do_reset();
        run_cycle(1, 32'hFFFFFFF8, 0, 1, 0);
        run_cycle(0, 32'h0, 1, 1, 0);
        check("wrap_pc0", obs_pc, 32'hFFFFFFF8);
        run_cycle(0, 32'h0, 1, 1, 0);
        check("wrap_pc1", obs_pc, 32'hFFFFFFFC);
        run_cycle(0, 32'h0, 1, 1, 0);
        check("wrap_rd2", obs_rd, 1);
        check("wrap_pc2", obs_pc, 32'h00000000);
        for (int i = 0; i < 4; i++) run_cycle(0, 32'h0, 1, 1, 0);

        // Randomized traffic against the program-order stream model.
        do_reset();
        rand_faults = 1;
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          br;
            logic [31:0] bpc;
            br  = ($urandom_range(0, 19) == 0);
            bpc = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            run_cycle(br, bpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 3);
        end
        check("random_progress", delivered > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
